float_to_int_pipe: RTL and testbench

FLOAT_TO_INT_PIPE -- requirements
Module: float_to_int_pipe

---
 rtl/float_to_int_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_float_to_int_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int_pipe.sv
// ---------------------------------------------------------------------------
// float_to_int_pipe
//
// Converts a small unsigned-exponent float {sign, exp, man} into a saturating
// two's-complement integer through a three-stage pipeline:
//   stage 1  decode/shift    : integer part of 0.man x 2^exp, half bit
//   stage 2  round/negate    : optional +1/2 rounding, negated magnitude
//   stage 3  saturate/output : overflow/underflow flags, registered result
//
// The operand value is (-1)^sign x 0.man x 2^exp. man is used literally (no
// hidden bit), and man == 0 is zero whatever the sign and exponent.
//
// Optional feature (macro F2I_ROUND_NEAREST_EN):
//   defined   : magnitude rounds half away from zero before saturation
//   undefined : magnitude truncates toward zero (default build)
//   Latency is three cycles in both builds.
//
// Parameters
//   EXP_W  exponent width, unsigned (1..6)
//   MAN_W  explicit significand width (2..16)
//   INT_W  signed result width (2..32)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   float_i      operand {sign, exp, man}
//   valid_i      float_i valid this cycle
//   ready_o      converter accepts float_i this cycle (= pipeline enable)
//   int_o        two's-complement result
//   overflow     result saturated (qualified by valid_o)
//   underflow    nonzero operand converted to 0 (qualified by valid_o)
//   valid_o      int_o / overflow / underflow valid
//   ready_i      downstream accepts the result
//   clr_count_i  synchronous clear of ovf_count_o (wins over increment)
//   ovf_count_o  saturating count of delivered overflow results
// ---------------------------------------------------------------------------
module float_to_int_pipe #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 8,
   parameter int INT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [EXP_W+MAN_W:0]   float_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [INT_W-1:0]       int_o,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   valid_o,
   input  logic                   ready_i,
   input  logic                   clr_count_i,
   output logic [7:0]             ovf_count_o
);

   // Largest exponent value; the shifter is wide enough that no exponent can
   // push significand bits off the top, and the integer part always has at
   // least INT_W+1 bits.
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam int SH_W = MAN_W + EMAX + INT_W;

   // Magnitude limits (INT_W+1 bits so a rounding carry is still visible).
   localparam logic [INT_W:0]   MAG_MAX_POS = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [INT_W:0]   MAG_MAX_NEG = {2'b01, {(INT_W-1){1'b0}}};
   localparam logic [INT_W-1:0] SAT_POS     = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] SAT_NEG     = {1'b1, {(INT_W-1){1'b0}}};

   // ------------------------------------------------------------------------
   // Handshake: the whole pipeline advances together.
   // ------------------------------------------------------------------------
   logic en;
   assign en      = ~valid_o | ready_i;
   assign ready_o = en;

   // ------------------------------------------------------------------------
   // Stage 1: decode and shift
   // ------------------------------------------------------------------------
   logic             sign_in;
   logic [EXP_W-1:0] exp_in;
   logic [MAN_W-1:0] man_in;
   assign {sign_in, exp_in, man_in} = float_i;

   logic [SH_W-1:0]  int_part;
   logic             s1_big_d;
   logic [INT_W-1:0] s1_mag_d;
   logic             s1_half_d;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      // floor(0.man x 2^exp): scale man by 2^exp, then drop the MAN_W
      // fraction bits.
      int_part  = (SH_W'(man_in) << exp_in) >> MAN_W;
      s1_big_d  = |int_part[SH_W-1:INT_W];   // magnitude >= 2^INT_W
      s1_mag_d  = int_part[INT_W-1:0];
      s1_half_d = 1'b0;
`ifdef F2I_ROUND_NEAREST_EN
      // The 2^-1 bit of the scaled value is man[MAN_W-1-exp]; it only exists
      // while exp < MAN_W.
      if (int'(exp_in) < MAN_W)
         s1_half_d = |(man_in & (MAN_W'(1) << (MAN_W - 1 - int'(exp_in))));
`endif
   end

   logic             s1_valid_q;
   logic             s1_sign_q;
   logic             s1_nz_q;
   logic             s1_big_q;
   logic [INT_W-1:0] s1_mag_q;
   logic             s1_half_q;

   // ------------------------------------------------------------------------
   // Stage 2: round and negate
   // ------------------------------------------------------------------------
   logic [INT_W:0]   s2_mag_d;
   logic [INT_W-1:0] s2_neg_d;

   always_comb begin
      // Half bit is 0 in the truncating build, so this is a plain copy there.
      s2_mag_d = {1'b0, s1_mag_q} + {{INT_W{1'b0}}, s1_half_q};
      s2_neg_d = INT_W'(0) - s2_mag_d[INT_W-1:0];
   end

   logic             s2_valid_q;
   logic             s2_sign_q;
   logic             s2_nz_q;
   logic             s2_big_q;
   logic [INT_W:0]   s2_mag_q;
   logic [INT_W-1:0] s2_neg_q;

   // ------------------------------------------------------------------------
   // Stage 3: saturate and flag
   // ------------------------------------------------------------------------
   logic [INT_W:0]   mag_lim;
   logic             ovf_d;
   logic             unf_d;
   logic [INT_W-1:0] int_d;

   always_comb begin
      // A negative result may reach 2^(INT_W-1), a positive one only 2^(INT_W-1)-1.
      mag_lim = s2_sign_q ? MAG_MAX_NEG : MAG_MAX_POS;
      ovf_d   = s2_big_q | (s2_mag_q > mag_lim);
      // Flags are exclusive: a saturated result is never an underflow.
      unf_d   = s2_nz_q & ~ovf_d & (s2_mag_q == '0);
      if (ovf_d)
         int_d = s2_sign_q ? SAT_NEG : SAT_POS;
      else
         int_d = s2_sign_q ? s2_neg_q : s2_mag_q[INT_W-1:0];
   end

   // ------------------------------------------------------------------------
   // Control state: valid chain and registered outputs
   // ------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // stage samples the value its predecessor held before this clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         valid_o    <= 1'b0;
         int_o      <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (en) begin
         s1_valid_q <= valid_i;
         s2_valid_q <= s1_valid_q;
         valid_o    <= s2_valid_q;
         // Outputs only load real results; during a bubble they keep the last
         // one, which valid_o already marks as stale.
         if (s2_valid_q) begin
            int_o     <= int_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Payload registers
   // ------------------------------------------------------------------------
   // NOTE: payload registers have no reset: they are only ever read through
   // their stage valid bit, which is reset, so clearing them adds nothing.
   always_ff @(posedge clk) begin
      if (en && valid_i) begin
         s1_sign_q <= sign_in;
         s1_nz_q   <= |man_in;
         s1_big_q  <= s1_big_d;
         s1_mag_q  <= s1_mag_d;
         s1_half_q <= s1_half_d;
      end
      if (en && s1_valid_q) begin
         s2_sign_q <= s1_sign_q;
         s2_nz_q   <= s1_nz_q;
         s2_big_q  <= s1_big_q;
         s2_mag_q  <= s2_mag_d;
         s2_neg_q  <= s2_neg_d;
      end
   end

   // ------------------------------------------------------------------------
   // Overflow counter: counts results actually handed downstream.
   // ------------------------------------------------------------------------
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = ovf_count_o;
      if (clr_count_i)
         cnt_d = '0;
      else if (valid_o && ready_i && overflow && (ovf_count_o != 8'hFF))
         cnt_d = ovf_count_o + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_count_o <= '0;
      else
         ovf_count_o <= cnt_d;
   end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// ---------------------------------------------------------------------------
// tb_float_to_int_pipe
//
// Self-checking bench for float_to_int_pipe at default parameters. Expected
// values follow the build: define F2I_ROUND_NEAREST_EN for the rounding build.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_float_to_int_pipe;

   localparam int EXP_W = 4;
   localparam int MAN_W = 8;
   localparam int INT_W = 8;
   localparam int FW    = 1 + EXP_W + MAN_W;

`ifdef F2I_ROUND_NEAREST_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [FW-1:0]    float_i;
   logic             valid_i;
   logic             ready_o;
   logic [INT_W-1:0] int_o;
   logic             overflow;
   logic             underflow;
   logic             valid_o;
   logic             ready_i;
   logic             clr_count_i;
   logic [7:0]       ovf_count_o;

   int total = 0;
   int bad   = 0;
   int exp_cnt;

   int               sent, got, n, idx;
   logic             seen;
   logic [22:0]      sq[$];
   logic [22:0]      item;

   float_to_int_pipe #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W),
      .INT_W(INT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .float_i     (float_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .int_o       (int_o),
      .overflow    (overflow),
      .underflow   (underflow),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .clr_count_i (clr_count_i),
      .ovf_count_o (ovf_count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: value x 256 = man << exp, so the integer part is that >> 8.
   function automatic logic [9:0] model(input logic [12:0] f);
      longint v, mag;
      logic   ovf, unf;
      logic [7:0] r;
      v   = longint'(f[7:0]) << f[11:8];
      mag = RND ? ((v + 128) >> 8) : (v >> 8);
      ovf = f[12] ? (mag > 128) : (mag > 127);
      if (ovf)
         r = f[12] ? 8'h80 : 8'h7F;
      else
         r = f[12] ? 8'(-mag) : 8'(mag);
      unf = (f[7:0] != 8'd0) && !ovf && (mag == 0);
      return {ovf, unf, r};
   endfunction

   // One operand through an empty pipeline, checking the 3-cycle latency.
   task automatic run_one(input logic [12:0] f,
                          input logic [7:0] ti, input bit to, input bit tu,
                          input logic [7:0] ri, input bit ro, input bit ru,
                          input string tag);
      logic [7:0] ei;
      logic       eo, eu;
      ei = RND ? ri : ti;
      eo = RND ? ro : to;
      eu = RND ? ru : tu;
      float_i = f;
      valid_i = 1'b1;
      ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      check({tag, "_lat1"}, valid_o, 0);
      step();
      check({tag, "_lat2"}, valid_o, 0);
      step();
      check({tag, "_valid"}, valid_o, 1);
      check({tag, "_int"}, int_o, ei);
      check({tag, "_flags"}, {overflow, underflow}, {eo, eu});
      step();
      if (eo && exp_cnt < 255) exp_cnt++;
      check({tag, "_cnt"}, ovf_count_o, exp_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      valid_i     = 1'b0;
      ready_i     = 1'b1;
      clr_count_i = 1'b0;
      float_i     = '0;
      exp_cnt     = 0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_int", int_o, 0);
      check("rst_flags", {overflow, underflow}, 0);
      check("rst_cnt", ovf_count_o, 0);
      check("rst_ready", ready_o, 1);
      reset = 1'b0;
      step();
      check("rel_ready", ready_o, 1);

      // ---------------- directed vectors ----------------
      //       float_i   trunc int/ovf/unf   round int/ovf/unf
      run_one(13'h03A0, 8'h05, 0, 0, 8'h05, 0, 0, "pos5");
      run_one(13'h13A0, 8'hFB, 0, 0, 8'hFB, 0, 0, "neg5");
      run_one(13'h0880, 8'h7F, 1, 0, 8'h7F, 1, 0, "pos128");
      run_one(13'h1880, 8'h80, 0, 0, 8'h80, 0, 0, "neg128");
      run_one(13'h0080, 8'h00, 0, 1, 8'h01, 0, 0, "half");
      run_one(13'h01C0, 8'h01, 0, 0, 8'h02, 0, 0, "one_half");
      run_one(13'h1500, 8'h00, 0, 0, 8'h00, 0, 0, "neg_zero");
      run_one(13'h1FFF, 8'h80, 1, 0, 8'h80, 1, 0, "neg_huge");
      run_one(13'h17FF, 8'h81, 0, 0, 8'h80, 0, 0, "neg127_5");
      run_one(13'h07FF, 8'h7F, 0, 0, 8'h7F, 1, 0, "pos127_5");
      run_one(13'h1040, 8'h00, 0, 1, 8'h00, 0, 1, "neg_quarter");
      run_one(13'h1180, 8'hFF, 0, 0, 8'hFF, 0, 0, "neg_one");

      // ---------------- stream of 10 with a 3-cycle stall ----------------
      sent = 0;
      got  = 0;
      for (int c = 0; c < 40 && got < 10; c++) begin
         ready_i = !(c >= 4 && c <= 6);
         valid_i = (sent < 10);
         float_i = {1'b0, 4'd4, 8'((sent + 1) * 16)};
         #1;
         if (valid_o) begin
            check($sformatf("stream_int%0d", got), int_o, got + 1);
            if (!ready_i)
               check("stream_stall_ready", ready_o, 0);
            else
               got++;
         end
         if (valid_i && ready_o) sent++;
         step();
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      check("stream_count", got, 10);
      seen = 1'b0;
      repeat (5) begin
         step();
         seen = seen | valid_o;
      end
      check("stream_no_dup", seen, 0);

      // ---------------- reset with operands in flight ----------------
      for (int i = 0; i < 3; i++) begin
         float_i = {1'b0, 4'd4, 8'((i + 1) * 16)};
         valid_i = 1'b1;
         step();
      end
      valid_i = 1'b0;
      check("midrst_inflight", valid_o, 1);
      reset = 1'b1;
      #1;
      check("midrst_valid", valid_o, 0);
      check("midrst_ready", ready_o, 1);
      check("midrst_cnt", ovf_count_o, 0);
      exp_cnt = 0;
      step();
      reset = 1'b0;
      seen  = 1'b0;
      repeat (6) begin
         step();
         seen = seen | valid_o;
      end
      check("midrst_none", seen, 0);
      run_one(13'h03A0, 8'h05, 0, 0, 8'h05, 0, 0, "post_rst");

      // ---------------- counter saturation and clear ----------------
      ready_i = 1'b1;
      valid_i = 1'b1;
      float_i = 13'h0880;
      repeat (303) step();
      check("sat_cnt", ovf_count_o, 255);
      check("sat_streaming", {valid_o, overflow}, 2'b11);
      clr_count_i = 1'b1;
      step();
      clr_count_i = 1'b0;
      check("clr_priority", ovf_count_o, 0);
      step();
      valid_i = 1'b0;
      check("clr_then_inc", ovf_count_o, 1);
      repeat (4) step();
      check("sat_drain", ovf_count_o, 4);

      // ---------------- exhaustive sweep at full rate ----------------
      n   = 0;
      idx = 0;
      ready_i = 1'b1;
      for (int c = 0; c < 8195; c++) begin
         valid_i = (idx < 8192);
         float_i = 13'(idx);
         #1;
         if (valid_o) begin
            if (sq.size() > 0) begin
               item = sq.pop_front();
               check($sformatf("sweep_%04h", item[22:10]), {overflow, underflow, int_o}, item[9:0]);
            end else begin
               check("sweep_extra", valid_o, 0);
            end
            n++;
         end
         if (valid_i && ready_o) begin
            sq.push_back({float_i, model(float_i)});
            idx++;
         end
         step();
      end
      valid_i = 1'b0;
      check("sweep_throughput", n, 8192);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
